// File: rtl/alpharetz_spi_queue_if.sv
// CPU-side and controller-side signal bundle of the SPI command/response queue.
// The queue connects through the slave modport; the CPU/controller side (or a
// bench standing in for both) connects through the master modport.
interface alpharetz_spi_queue_if #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH   = 2,
    parameter int FIFO_DEPTH     = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // CPU write side (TX queue)
    logic                      wr_valid;
    logic                      wr_ready;
    logic [SPI_DATA_WIDTH-1:0] wr_data;
    logic [P_ADDR_WIDTH-1:0]   wr_addr;
    // CPU read side (RX queue)
    logic                      rd_valid;
    logic                      rd_ready;
    logic [SPI_DATA_WIDTH-1:0] rd_data;
    logic [P_ADDR_WIDTH-1:0]   rd_addr;
    // Status
    logic [CW-1:0]             tx_count;
    logic [CW-1:0]             rx_count;
    logic                      err_timeout;
    logic                      clr_err;
    // SPI controller side
    logic [SPI_DATA_WIDTH-1:0] ctl_tx_data;
    logic [P_ADDR_WIDTH-1:0]   ctl_p_addr;
    logic                      ctl_start_txn;
    logic                      ctl_busy;
    logic                      ctl_end_txn;
    logic [SPI_DATA_WIDTH-1:0] ctl_rx_data;

    modport slave (
        input  wr_valid, wr_data, wr_addr, rd_ready, clr_err,
               ctl_busy, ctl_end_txn, ctl_rx_data,
        output wr_ready, rd_valid, rd_data, rd_addr, tx_count, rx_count,
               err_timeout, ctl_tx_data, ctl_p_addr, ctl_start_txn
    );

    modport master (
        output wr_valid, wr_data, wr_addr, rd_ready, clr_err,
               ctl_busy, ctl_end_txn, ctl_rx_data,
        input  wr_ready, rd_valid, rd_data, rd_addr, tx_count, rx_count,
               err_timeout, ctl_tx_data, ctl_p_addr, ctl_start_txn
    );
endinterface

// File: rtl/alpharetz_spi_queue.sv
// Command/response queue in front of alpharetz_spi_controller. CPU transfers
// are buffered in a TX FIFO and launched one at a time; each response is
// stored in an RX FIFO tagged with the peripheral address. A watchdog drops
// transfers the controller never completes and raises a sticky error.
module alpharetz_spi_queue #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH   = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   sys_clk,
    input  logic                   async_rst,
    input  logic                   sys_clk_en,
    alpharetz_spi_queue_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = P_ADDR_WIDTH + SPI_DATA_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [EW-1:0]   tx_mem_r [FIFO_DEPTH];
    logic [EW-1:0]   rx_mem_r [FIFO_DEPTH];
    logic [AW-1:0]   tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
    logic [CW-1:0]   tx_count_r, rx_count_r;
    logic [TW-1:0]   wdog_r;
    logic            end_prev_r;
    logic            err_r;

    logic            tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic            tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic            end_edge_s, err_set_s;

    assign tx_full_s  = (tx_count_r == CW'(FIFO_DEPTH));
    assign tx_empty_s = (tx_count_r == {CW{1'b0}});
    assign rx_full_s  = (rx_count_r == CW'(FIFO_DEPTH));
    assign rx_empty_s = (rx_count_r == {CW{1'b0}});
    assign tx_push_s  = bus.wr_valid && !tx_full_s;
    assign rx_pop_s   = bus.rd_ready && !rx_empty_s;
    assign end_edge_s = bus.ctl_end_txn && !end_prev_r;

    assign bus.wr_ready      = !tx_full_s;
    assign bus.rd_valid      = !rx_empty_s;
    assign bus.tx_count      = tx_count_r;
    assign bus.rx_count      = rx_count_r;
    assign bus.err_timeout   = err_r;
    assign bus.ctl_start_txn = (state_r == ST_ISSUE);
    assign {bus.ctl_p_addr, bus.ctl_tx_data} = tx_mem_r[tx_rptr_r];
    assign {bus.rd_addr, bus.rd_data}        = rx_mem_r[rx_rptr_r];

    // Next-state decode and FIFO pop/push strobes of the transfer sequencer.
    always_comb begin
        state_nxt_s = state_r;
        tx_pop_s    = 1'b0;
        rx_push_s   = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!tx_empty_s && !rx_full_s && !bus.ctl_busy) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.ctl_busy) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A completion edge beats a watchdog expiry in the same cycle.
                if (end_edge_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else if (wdog_r == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt_s = ST_IDLE;
                    tx_pop_s    = 1'b1;
                    err_set_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                rx_push_s   = 1'b1;
                tx_pop_s    = 1'b1;
                state_nxt_s = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.ctl_busy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, watchdog, end_txn edge history and sticky error flag.
    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            state_r    <= ST_IDLE;
            wdog_r     <= {TW{1'b0}};
            end_prev_r <= 1'b0;
            err_r      <= 1'b0;
        end else if (sys_clk_en) begin
            state_r    <= state_nxt_s;
            end_prev_r <= bus.ctl_end_txn;
            // Watchdog only runs while waiting, so it restarts at 0 on every entry.
            if (state_r == ST_WAIT) begin
                wdog_r <= wdog_r + TW'(1);
            end else begin
                wdog_r <= {TW{1'b0}};
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (bus.clr_err) begin
                err_r <= 1'b0;
            end
        end
    end

    // TX FIFO: storage, pointers and occupancy.
    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_r[i] <= {EW{1'b0}};
            end
            tx_wptr_r  <= {AW{1'b0}};
            tx_rptr_r  <= {AW{1'b0}};
            tx_count_r <= {CW{1'b0}};
        end else if (sys_clk_en) begin
            if (tx_push_s) begin
                tx_mem_r[tx_wptr_r] <= {bus.wr_addr, bus.wr_data};
                tx_wptr_r           <= tx_wptr_r + AW'(1);
            end
            if (tx_pop_s) begin
                tx_rptr_r <= tx_rptr_r + AW'(1);
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CW'(1);
                2'b01:   tx_count_r <= tx_count_r - CW'(1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // RX FIFO: captured responses tagged with the issuing peripheral address.
    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem_r[i] <= {EW{1'b0}};
            end
            rx_wptr_r  <= {AW{1'b0}};
            rx_rptr_r  <= {AW{1'b0}};
            rx_count_r <= {CW{1'b0}};
        end else if (sys_clk_en) begin
            if (rx_push_s) begin
                rx_mem_r[rx_wptr_r] <= {bus.ctl_p_addr, bus.ctl_rx_data};
                rx_wptr_r           <= rx_wptr_r + AW'(1);
            end
            if (rx_pop_s) begin
                rx_rptr_r <= rx_rptr_r + AW'(1);
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CW'(1);
                2'b01:   rx_count_r <= rx_count_r - CW'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end
endmodule
